// File: rtl/seq_match_ctrl.sv
// Programmable bit-serial pattern detector with a run controller.
// A legal start latches pattern, length and window size. Each accepted bit
// shifts into a history register and is compared against the latched pattern.
// Overlapping matches are counted, and the run ends after nbits accepts.
module seq_match_ctrl #(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4,
    parameter int CNTW   = 8,
    parameter int NW     = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [MAXLEN-1:0] pat,
    input  logic [LENW-1:0]   len,
    input  logic [NW-1:0]     nbits,
    input  logic              d_valid,
    input  logic              d_in,
    output logic              d_ready,
    output logic              found,
    output logic [CNTW-1:0]   match_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [MAXLEN-1:0] pat_l;
    logic [LENW-1:0]   len_l;
    logic [NW-1:0]     remaining;
    logic [MAXLEN-1:0] sh;
    logic [LENW-1:0]   fill;

    logic              cmd_legal;
    logic              load;
    logic              accept;
    logic [MAXLEN-1:0] sh_new;
    logic [LENW:0]     fill_inc;
    logic [MAXLEN-1:0] len_mask;
    logic              hit;

    // Command check, accept decode and match compare on the post-shift value
    always_comb begin
        cmd_legal = (len != '0) && (len <= LENW'(MAXLEN)) && (nbits != '0);
        load      = (state == IDLE) && start && cmd_legal;
        accept    = d_valid && (state == RUN);
        sh_new    = {sh[MAXLEN-2:0], d_in};
        fill_inc  = {1'b0, fill} + (LENW+1)'(1);
        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (i < int'(len_l));
        end
        // The window is full once this accept brings fill up to len.
        hit = accept && (fill_inc >= {1'b0, len_l})
                     && ((sh_new & len_mask) == (pat_l & len_mask));
    end

    // State register
    always_ff @(posedge clock or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_next = state;
        d_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                d_ready = 1'b1;
                busy    = 1'b1;
                if (accept && (remaining == NW'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: command latch, shift history, counters and registered pulses
    always_ff @(posedge clock or posedge rst) begin
        // NOTE: the latched command registers are reset as well. They are only
        // a few flops, and resetting them keeps post-reset behaviour fully defined.
        if (rst) begin
            pat_l     <= '0;
            len_l     <= '0;
            remaining <= '0;
            sh        <= '0;
            fill      <= '0;
            match_cnt <= '0;
            found     <= 1'b0;
            err       <= 1'b0;
        end else begin
            found <= hit;
            err   <= (state == IDLE) && start && !cmd_legal;
            if (load) begin
                pat_l     <= pat;
                len_l     <= len;
                remaining <= nbits;
                sh        <= '0;
                fill      <= '0;
                match_cnt <= '0;
            end else if (accept) begin
                sh        <= sh_new;
                remaining <= remaining - NW'(1);
                if (fill_inc >= {1'b0, len_l}) begin
                    fill <= len_l;
                end else begin
                    fill <= fill_inc[LENW-1:0];
                end
                if (hit && (match_cnt != {CNTW{1'b1}})) begin
                    match_cnt <= match_cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl.
// The stimulus pushes the expected found/done/err events into queues. Monitors
// pop an entry and compare it each time a DUT asserts one of those pulses.
// A second instance with a 2-bit counter shares all inputs and covers saturation.
module tb_seq_match_ctrl;

    localparam int MAXLEN = 8;
    localparam int LENW   = 4;
    localparam int NW     = 16;

    logic              clock = 1'b0;
    logic              rst;
    logic              start;
    logic [MAXLEN-1:0] pat;
    logic [LENW-1:0]   len;
    logic [NW-1:0]     nbits;
    logic              d_valid;
    logic              d_in;

    logic              d_ready, found, busy, done, err;
    logic [7:0]        match_cnt;
    logic              sat_d_ready, sat_found, sat_busy, sat_done, sat_err;
    logic [1:0]        sat_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       found;
        logic       done;
        logic       err;
        logic [7:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t sat_q[$];

    seq_match_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(8), .NW(NW)) dut (
        .clock(clock), .rst(rst), .start(start), .pat(pat), .len(len),
        .nbits(nbits), .d_valid(d_valid), .d_in(d_in), .d_ready(d_ready),
        .found(found), .match_cnt(match_cnt), .busy(busy), .done(done), .err(err)
    );

    seq_match_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(2), .NW(NW)) dut_sat (
        .clock(clock), .rst(rst), .start(start), .pat(pat), .len(len),
        .nbits(nbits), .d_valid(d_valid), .d_in(d_in), .d_ready(sat_d_ready),
        .found(sat_found), .match_cnt(sat_cnt), .busy(sat_busy), .done(sat_done),
        .err(sat_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void expect_ev(input logic f, input logic d, input logic e, input int cnt);
        ev_t m;
        ev_t s;
        m = '{found: f, done: d, err: e, cnt: 8'(cnt)};
        s = '{found: f, done: d, err: e, cnt: 8'((cnt > 3) ? 3 : cnt)};
        exp_q.push_back(m);
        sat_q.push_back(s);
    endfunction

    // Main-instance monitor: every pulse must match the next expected event
    always @(negedge clock) begin
        ev_t e;
        if (!rst && (found || done || err)) begin
            if (exp_q.size() == 0) begin
                check("main_unexpected_event", 32'({found, done, err, match_cnt}), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("main_event", 32'({found, done, err, match_cnt}), 32'(e));
            end
        end
    end

    // Saturating-instance monitor
    always @(negedge clock) begin
        ev_t e;
        if (!rst && (sat_found || sat_done || sat_err)) begin
            if (sat_q.size() == 0) begin
                check("sat_unexpected_event", 32'({sat_found, sat_done, sat_err, 6'b0, sat_cnt}), 32'h0);
            end else begin
                e = sat_q.pop_front();
                check("sat_event", 32'({sat_found, sat_done, sat_err, 6'b0, sat_cnt}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_start(input logic [7:0] p, input logic [3:0] l, input logic [15:0] n);
        start = 1'b1;
        pat   = p;
        len   = l;
        nbits = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        d_valid = 1'b1;
        d_in    = b;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || sat_q.size() != 0); i++) begin
            tick();
        end
        check(name, 32'(exp_q.size() + sat_q.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] s101;
        logic [9:0] sa5;
        s101 = 5'b10101;
        sa5  = 10'b1010010100;

        rst = 1'b1; start = 1'b0; pat = '0; len = '0; nbits = '0;
        d_valid = 1'b0; d_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_found", 32'(found), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_d_ready", 32'(d_ready), 32'h0);
        check("reset_match_cnt", 32'(match_cnt), 32'h0);
        rst = 1'b0;
        tick();

        // Basic: 101 over 10101, continuous valid
        expect_ev(1'b1, 1'b0, 1'b0, 1);
        expect_ev(1'b1, 1'b1, 1'b0, 2);
        issue_start(8'h05, 4'd3, 16'd5);
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_d_ready", 32'(d_ready), 32'h1);
        for (int i = 4; i >= 0; i--) send_bit(s101[i]);
        tick();
        check("basic_busy_after_done", 32'(busy), 32'h0);
        check("basic_final_cnt", 32'(match_cnt), 32'h2);
        drain("basic_drain");

        // Handshake gaps: two idle cycles between bits
        expect_ev(1'b1, 1'b0, 1'b0, 1);
        expect_ev(1'b1, 1'b1, 1'b0, 2);
        issue_start(8'h05, 4'd3, 16'd5);
        for (int i = 4; i >= 0; i--) begin
            send_bit(s101[i]);
            if (i != 0) begin
                for (int g = 0; g < 2; g++) begin
                    check("gap_d_ready", 32'(d_ready), 32'h1);
                    tick();
                end
            end
        end
        tick();
        check("gap_busy_after_done", 32'(busy), 32'h0);
        check("gap_final_cnt", 32'(match_cnt), 32'h2);
        drain("gap_drain");

        // Illegal commands: len=0, len=MAXLEN+1, nbits=0
        for (int k = 0; k < 3; k++) begin
            expect_ev(1'b0, 1'b0, 1'b1, 2);
            case (k)
                0:       issue_start(8'h05, 4'd0, 16'd5);
                1:       issue_start(8'h05, 4'(MAXLEN + 1), 16'd5);
                default: issue_start(8'h05, 4'd3, 16'd0);
            endcase
            check("illegal_busy", 32'(busy), 32'h0);
            check("illegal_d_ready", 32'(d_ready), 32'h0);
            tick();
            check("illegal_cnt_held", 32'(match_cnt), 32'h2);
        end
        drain("illegal_drain");

        // Saturation: len=1, pattern bit 1, six ones (2-bit instance stops at 3)
        for (int i = 0; i < 6; i++) expect_ev(1'b1, (i == 5), 1'b0, i + 1);
        issue_start(8'h01, 4'd1, 16'd6);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        tick();
        check("sat_final_cnt", 32'(sat_cnt), 32'h3);
        drain("sat_drain");

        // Full-length pattern A5, window 10, start pulsed mid-run
        expect_ev(1'b1, 1'b0, 1'b0, 1);
        expect_ev(1'b0, 1'b1, 1'b0, 1);
        issue_start(8'hA5, 4'd8, 16'd10);
        for (int i = 9; i >= 6; i--) send_bit(sa5[i]);
        start = 1'b1; pat = 8'h05; len = 4'd3; nbits = 16'd2;
        tick();
        start = 1'b0;
        check("midrun_start_busy", 32'(busy), 32'h1);
        for (int i = 5; i >= 0; i--) send_bit(sa5[i]);
        tick();
        check("a5_busy_after_done", 32'(busy), 32'h0);
        check("a5_final_cnt", 32'(match_cnt), 32'h1);
        drain("a5_drain");

        // Reset mid-run after two accepts: no done, outputs clear at once
        issue_start(8'h05, 4'd3, 16'd5);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        #1;
        check("rst_found", 32'(found), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_d_ready", 32'(d_ready), 32'h0);
        check("rst_match_cnt", 32'(match_cnt), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_idle", 32'(busy), 32'h0);
        expect_ev(1'b1, 1'b1, 1'b0, 1);
        issue_start(8'h05, 4'd3, 16'd3);
        for (int i = 2; i >= 0; i--) send_bit(s101[i]);
        tick();
        check("post_rst_cnt", 32'(match_cnt), 32'h1);
        drain("post_rst_drain");

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
